// File: rtl/regfile_wport_arb_pkg.sv
// Shared types and constants for the regfile write-port arbiter and its scoreboard.
package regfile_wport_arb_pkg;

    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegNum     = 32;

    localparam logic              WriteEnable = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord    = '0;

    typedef logic [RegAddrBus-1:0] reg_addr_t;
    typedef logic [RegBus-1:0]     reg_data_t;

    // Grant select for the single regfile write port.
    typedef enum logic [1:0] {
        WbSrcNone = 2'd0,
        WbSrcAlu  = 2'd1,
        WbSrcLsu  = 2'd2,
        WbSrcMdu  = 2'd3
    } wb_src_e;

    function automatic logic [RegNum-1:0] reg_onehot(input reg_addr_t addr);
        reg_onehot       = '0;
        reg_onehot[addr] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_wport_arb_if.sv
// Writeback bus: ALU/LSU/MDU write sources in, regfile write port and handshakes out.
interface regfile_wport_arb_if;
    import regfile_wport_arb_pkg::*;

    logic      alu_we;
    reg_addr_t alu_wa;
    reg_data_t alu_wd;
    logic      alu_hold;

    logic      lsu_req;
    reg_addr_t lsu_wa;
    reg_data_t lsu_wd;
    logic      lsu_ack;

    logic      mdu_req;
    reg_addr_t mdu_wa;
    reg_data_t mdu_wd;
    logic      mdu_ack;

    logic      we;
    reg_addr_t wa;
    reg_data_t wd;

    modport master (
        output alu_we, alu_wa, alu_wd,
        output lsu_req, lsu_wa, lsu_wd,
        output mdu_req, mdu_wa, mdu_wd,
        input  alu_hold, lsu_ack, mdu_ack,
        input  we, wa, wd
    );

    modport slave (
        input  alu_we, alu_wa, alu_wd,
        input  lsu_req, lsu_wa, lsu_wd,
        input  mdu_req, mdu_wa, mdu_wd,
        output alu_hold, lsu_ack, mdu_ack,
        output we, wa, wd
    );

endinterface

// File: rtl/regfile_wport_arb_wb_scoreboard.sv
// Busy mask of registers awaiting a long-latency write, with two-port decode stall lookup.
module wb_scoreboard
    import regfile_wport_arb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set_en,
    input  reg_addr_t set_wa,
    input  logic      clr_en,
    input  reg_addr_t clr_wa,
    input  reg_addr_t ra1,
    input  logic      re1,
    input  reg_addr_t ra2,
    input  logic      re2,
    output logic      stall
);

    logic [RegNum-1:0] busy_q, busy_d;

    // Set is applied after clear so a same-cycle set/clear leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d = busy_d & ~reg_onehot(clr_wa);
        end
        if (set_en) begin
            busy_d = busy_d | reg_onehot(set_wa);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign stall = (re1 && busy_q[ra1]) || (re2 && busy_q[ra2]);

endmodule

// File: rtl/regfile_wport_arb.sv
// Regfile write-port arbiter: ALU first, LSU/MDU round-robin, registered write port.
// Optional starvation guard enabled by REGFILE_WPORT_STARVE_GUARD_EN.
module regfile_wport_arb
    import regfile_wport_arb_pkg::*;
`ifdef REGFILE_WPORT_STARVE_GUARD_EN
#(
    parameter int unsigned STARVE_MAX = 8
)
`endif
(
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst_n,
    regfile_wport_arb_if.slave       bus,
    input  logic                     iss_valid,
    input  logic                     iss_long,
    input  reg_addr_t                iss_wa,
    input  reg_addr_t                ra1,
    input  logic                     re1,
    input  reg_addr_t                ra2,
    input  logic                     re2,
    output logic                     stall_o
);

    wb_src_e   src;
    logic      alu_valid;
    logic      lw_grant;
    reg_addr_t grant_wa;
    reg_data_t grant_wd;

    // rr_q = 0 prefers the LSU, 1 prefers the MDU.
    logic      rr_q;
    logic      we_q;
    reg_addr_t wa_q;
    reg_data_t wd_q;

    assign alu_valid = bus.alu_we && (bus.alu_wa != '0);

    always_comb begin
        src = WbSrcNone;
        if (alu_valid) begin
            src = WbSrcAlu;
        end else if (bus.lsu_req && (!bus.mdu_req || !rr_q)) begin
            src = WbSrcLsu;
        end else if (bus.mdu_req) begin
            src = WbSrcMdu;
        end
    end

    always_comb begin
        grant_wa = '0;
        grant_wd = ZeroWord;
        unique case (src)
            WbSrcAlu: begin
                grant_wa = bus.alu_wa;
                grant_wd = bus.alu_wd;
            end
            WbSrcLsu: begin
                grant_wa = bus.lsu_wa;
                grant_wd = bus.lsu_wd;
            end
            WbSrcMdu: begin
                grant_wa = bus.mdu_wa;
                grant_wd = bus.mdu_wd;
            end
            default: ;
        endcase
    end

    assign lw_grant    = (src == WbSrcLsu) || (src == WbSrcMdu);
    // Acks are forced low while reset is held so no pending request is consumed.
    assign bus.lsu_ack = cpu_rst_n && (src == WbSrcLsu);
    assign bus.mdu_ack = cpu_rst_n && (src == WbSrcMdu);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            we_q <= ~WriteEnable;
            wa_q <= '0;
            wd_q <= ZeroWord;
            rr_q <= 1'b0;
        end else begin
            we_q <= ((src != WbSrcNone) && (grant_wa != '0)) ? WriteEnable : ~WriteEnable;
            if (src != WbSrcNone) begin
                wa_q <= grant_wa;
                wd_q <= grant_wd;
            end
            if (src == WbSrcLsu) begin
                rr_q <= 1'b1;
            end else if (src == WbSrcMdu) begin
                rr_q <= 1'b0;
            end
        end
    end

    assign bus.we = we_q;
    assign bus.wa = wa_q;
    assign bus.wd = wd_q;

    wb_scoreboard u_scoreboard (
        .clk    (cpu_clk_50M),
        .rst_n  (cpu_rst_n),
        .set_en (iss_valid && iss_long),
        .set_wa (iss_wa),
        .clr_en (lw_grant),
        .clr_wa (grant_wa),
        .ra1    (ra1),
        .re1    (re1),
        .ra2    (ra2),
        .re2    (re2),
        .stall  (stall_o)
    );

`ifdef REGFILE_WPORT_STARVE_GUARD_EN
    localparam int unsigned CntW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    logic [CntW-1:0] starve_q;
    logic            hold_q;
    logic            blocked;

    assign blocked = alu_valid && (bus.lsu_req || bus.mdu_req);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            hold_q <= 1'b0;
            if (lw_grant) begin
                starve_q <= '0;
            end else if (blocked) begin
                if (starve_q == CntW'(STARVE_MAX - 1)) begin
                    starve_q <= '0;
                    hold_q   <= 1'b1;
                end else begin
                    starve_q <= starve_q + 1'b1;
                end
            end
        end
    end

    assign bus.alu_hold = hold_q;
`else
    assign bus.alu_hold = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: random traffic against a reference model, a vector table,
// and hand sequences for reset and starvation (REGFILE_WPORT_STARVE_GUARD_EN aware).
module tb_regfile_wport_arb;

    logic       clk;
    logic       rst_n;
    logic       iss_valid;
    logic       iss_long;
    logic [4:0] iss_wa;
    logic [4:0] ra1;
    logic       re1;
    logic [4:0] ra2;
    logic       re2;
    logic       stall_o;

    regfile_wport_arb_if bus ();

    regfile_wport_arb dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .bus         (bus),
        .iss_valid   (iss_valid),
        .iss_long    (iss_long),
        .iss_wa      (iss_wa),
        .ra1         (ra1),
        .re1         (re1),
        .ra2         (ra2),
        .re2         (re2),
        .stall_o     (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        alu_we;
        logic [4:0]  alu_wa;
        logic [31:0] alu_wd;
        logic        lsu_req;
        logic [4:0]  lsu_wa;
        logic [31:0] lsu_wd;
        logic        mdu_req;
        logic [4:0]  mdu_wa;
        logic [31:0] mdu_wd;
        logic        iss;
        logic [4:0]  iss_wa;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        x_lack;
        logic        x_mack;
        logic        x_stall;
        logic        x_we;
        logic [4:0]  x_wa;
        logic [31:0] x_wd;
    } vec_t;

    vec_t tbl[22];

    // Reference model state: busy registers, who is preferred next, and the write port.
    bit          mb[32];
    bit          m_pref_mdu;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.alu_we  = 1'b0;
        bus.alu_wa  = 5'd0;
        bus.alu_wd  = 32'h0;
        bus.lsu_req = 1'b0;
        bus.lsu_wa  = 5'd0;
        bus.lsu_wd  = 32'h0;
        bus.mdu_req = 1'b0;
        bus.mdu_wa  = 5'd0;
        bus.mdu_wd  = 32'h0;
        iss_valid   = 1'b0;
        iss_long    = 1'b0;
        iss_wa      = 5'd0;
        re1         = 1'b0;
        ra1         = 5'd0;
        re2         = 1'b0;
        ra2         = 5'd0;
    endtask

    task automatic apply(input vec_t v);
        bus.alu_we  = v.alu_we;
        bus.alu_wa  = v.alu_wa;
        bus.alu_wd  = v.alu_wd;
        bus.lsu_req = v.lsu_req;
        bus.lsu_wa  = v.lsu_wa;
        bus.lsu_wd  = v.lsu_wd;
        bus.mdu_req = v.mdu_req;
        bus.mdu_wa  = v.mdu_wa;
        bus.mdu_wd  = v.mdu_wd;
        iss_valid   = v.iss;
        iss_long    = v.iss;
        iss_wa      = v.iss_wa;
        re1         = v.re1;
        ra1         = v.ra1;
        re2         = v.re2;
        ra2         = v.ra2;
    endtask

    task automatic check_port(input string tag, input logic xwe, input logic [4:0] xwa,
                              input logic [31:0] xwd);
        check({tag, "_we"}, 32'(bus.we), 32'(xwe));
        check({tag, "_wa"}, 32'(bus.wa), 32'(xwa));
        check({tag, "_wd"}, bus.wd, xwd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          l_pend;
        bit          m_pend;
        bit          alu_w;
        bit          gl;
        bit          gm;
        bit          x_stall;
        bit          l_wait;
        logic        x_hold;

        // Rows: alu | lsu | mdu | issue | reads | expected acks, stall, registered port.
        tbl[0]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h71, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
        tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h71, 1'b1, 5'd8, 32'h81, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 32'h88};
        tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h72, 1'b1, 5'd8, 32'h81, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h71};
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h81};
        tbl[5]  = '{1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6, 32'h22222222, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 32'h81};
        tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h22222222, 1'b0, 5'd0, 32'h0, 1'b0,
                    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h11111111};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h22222222};
        tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 32'h22222222};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h22222222};
        tbl[10] = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0,
                    1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h22222222};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0,
                    1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h33};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99};
        tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                    1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99};
        tbl[14] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hA9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                    1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h99};
        tbl[15] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'hA9};
        tbl[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB9, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hA9};
        tbl[17] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'hB9};
        tbl[18] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5, 1'b1, 5'd0,
                    1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'hB9};
        tbl[19] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h5};
        tbl[20] = '{1'b1, 5'd0, 32'h1234, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h5};
        tbl[21] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44};

        // Power-on reset with requests already present.
        idle();
        rst_n       = 1'b0;
        bus.lsu_req = 1'b1;
        bus.mdu_req = 1'b1;
        @(negedge clk);
        check("por_lsu_ack", 32'(bus.lsu_ack), 32'd0);
        check("por_mdu_ack", 32'(bus.mdu_ack), 32'd0);
        check("por_hold", 32'(bus.alu_hold), 32'd0);
        check("por_stall", 32'(stall_o), 32'd0);
        check_port("por", 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;

        // Random traffic against the reference model.
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
        m_pref_mdu = 1'b0;
        m_we       = 1'b0;
        m_wa       = 5'd0;
        m_wd       = 32'h0;
        l_pend     = 1'b0;
        m_pend     = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (!l_pend) begin
                bus.lsu_req = ($urandom_range(0, 2) != 0);
                bus.lsu_wa  = 5'($urandom_range(0, 15));
                bus.lsu_wd  = $urandom;
            end
            if (!m_pend) begin
                bus.mdu_req = ($urandom_range(0, 2) != 0);
                bus.mdu_wa  = 5'($urandom_range(0, 15));
                bus.mdu_wd  = $urandom;
            end
            bus.alu_we = ($urandom_range(0, 2) == 0);
            bus.alu_wa = 5'($urandom_range(0, 31));
            bus.alu_wd = $urandom;
`ifdef REGFILE_WPORT_STARVE_GUARD_EN
            if (bus.alu_hold) bus.alu_we = 1'b0;
`endif
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_long  = ($urandom_range(0, 1) == 0);
            iss_wa    = 5'($urandom_range(0, 15));
            re1       = ($urandom_range(0, 1) == 0);
            ra1       = 5'($urandom_range(0, 15));
            re2       = ($urandom_range(0, 1) == 0);
            ra2       = 5'($urandom_range(0, 15));
            @(negedge clk);

            alu_w = bus.alu_we && (bus.alu_wa != 5'd0);
            if (alu_w) begin
                gl = 1'b0;
                gm = 1'b0;
            end else if (bus.lsu_req && bus.mdu_req) begin
                gl = !m_pref_mdu;
                gm = m_pref_mdu;
            end else begin
                gl = bus.lsu_req;
                gm = bus.mdu_req;
            end
            x_stall = (re1 && mb[ra1]) || (re2 && mb[ra2]);

            check("rnd_lsu_ack", 32'(bus.lsu_ack), 32'(gl));
            check("rnd_mdu_ack", 32'(bus.mdu_ack), 32'(gm));
            check("rnd_stall", 32'(stall_o), 32'(x_stall));
            check_port("rnd", m_we, m_wa, m_wd);
`ifndef REGFILE_WPORT_STARVE_GUARD_EN
            check("rnd_hold", 32'(bus.alu_hold), 32'd0);
`endif

            l_pend = bus.lsu_req && !gl;
            m_pend = bus.mdu_req && !gm;
            if (alu_w) begin
                m_we = 1'b1;
                m_wa = bus.alu_wa;
                m_wd = bus.alu_wd;
            end else if (gl) begin
                m_we = (bus.lsu_wa != 5'd0);
                m_wa = bus.lsu_wa;
                m_wd = bus.lsu_wd;
            end else if (gm) begin
                m_we = (bus.mdu_wa != 5'd0);
                m_wa = bus.mdu_wa;
                m_wd = bus.mdu_wd;
            end else begin
                m_we = 1'b0;
            end
            if (gl) begin
                m_pref_mdu = 1'b1;
                mb[bus.lsu_wa] = 1'b0;
            end
            if (gm) begin
                m_pref_mdu = 1'b0;
                mb[bus.mdu_wa] = 1'b0;
            end
            if (iss_valid && iss_long && iss_wa != 5'd0) mb[iss_wa] = 1'b1;
        end

        // Mark r12 busy, then reset mid-stream with requests pending and a read of r12.
        @(posedge clk);
        #1;
        idle();
        iss_valid = 1'b1;
        iss_long  = 1'b1;
        iss_wa    = 5'd12;
        @(posedge clk);
        #1;
        idle();
        re1 = 1'b1;
        ra1 = 5'd12;
        @(negedge clk);
        check("pre_rst_stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.lsu_req = 1'b1;
        bus.lsu_wa  = 5'd7;
        bus.mdu_req = 1'b1;
        bus.mdu_wa  = 5'd8;
        @(negedge clk);
        check("rst_lsu_ack", 32'(bus.lsu_ack), 32'd0);
        check("rst_mdu_ack", 32'(bus.mdu_ack), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check_port("rst", 1'b0, 5'd0, 32'h0);

        // Vector table, starting with the release of reset.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) rst_n = 1'b1;
            apply(tbl[i]);
            @(negedge clk);
            check($sformatf("row%0d_lsu_ack", i), 32'(bus.lsu_ack), 32'(tbl[i].x_lack));
            check($sformatf("row%0d_mdu_ack", i), 32'(bus.mdu_ack), 32'(tbl[i].x_mack));
            check($sformatf("row%0d_stall", i), 32'(stall_o), 32'(tbl[i].x_stall));
            check_port($sformatf("row%0d", i), tbl[i].x_we, tbl[i].x_wa, tbl[i].x_wd);
        end

        // ALU writes every cycle while the LSU waits.
        l_wait = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            idle();
            bus.lsu_req = l_wait;
            bus.lsu_wa  = 5'd10;
            bus.lsu_wd  = 32'hAA;
            bus.alu_we  = 1'b1;
            bus.alu_wa  = 5'd11;
            bus.alu_wd  = 32'(k);
`ifdef REGFILE_WPORT_STARVE_GUARD_EN
            if (bus.alu_hold) bus.alu_we = 1'b0;
            x_hold = (k == 8);
`else
            x_hold = 1'b0;
`endif
            @(negedge clk);
            check($sformatf("starve%0d_hold", k), 32'(bus.alu_hold), 32'(x_hold));
            check($sformatf("starve%0d_lsu_ack", k), 32'(bus.lsu_ack), 32'(x_hold));
            if (bus.lsu_ack) l_wait = 1'b0;
        end
        @(posedge clk);
        #1;
        idle();
        bus.lsu_req = l_wait;
        bus.lsu_wa  = 5'd10;
        bus.lsu_wd  = 32'hAA;
        @(negedge clk);
`ifdef REGFILE_WPORT_STARVE_GUARD_EN
        check("starve_release_ack", 32'(bus.lsu_ack), 32'd0);
`else
        check("starve_release_ack", 32'(bus.lsu_ack), 32'd1);
`endif
        check("starve_release_hold", 32'(bus.alu_hold), 32'd0);

        @(posedge clk);
        #1;
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arb.md
# regfile_wport_arb

Write-port arbiter and long-latency scoreboard for the 32×32 integer register file. It merges three writeback sources onto the single regfile write port (`we`/`wa`/`wd`):
- the in-order ALU pipeline, which is never stalled by the arbiter;
- the load/store unit;
- the iterative multiply/divide unit.

It also tracks registers with outstanding long-latency writes and raises a decode stall when a read port targets one. It sits between the writeback stage, LSU/MDU and the regfile write port; its stall output feeds the pipeline control block.

## Interface
- `STARVE_MAX`, 8: consecutive blocked cycles of a pending LSU/MDU request before the ALU is held (guard builds only, see Configuration).
- `cpu_clk_50M` in 1: the block's single clock.
- `cpu_rst_n` in 1: reset, asynchronous, active-low.
- `alu_we`, `alu_wa`, `alu_wd`: ALU writeback; in 1/5/32.
- `lsu_req`, `lsu_wa`, `lsu_wd`: LSU writeback request; in 1/5/32. Held stable until acked.
- `lsu_ack` out 1: one-cycle grant pulse to the LSU.
- `mdu_req`, `mdu_wa`, `mdu_wd`, `mdu_ack`: MDU equivalents of the LSU signals.
- `iss_valid`, `iss_long`, `iss_wa`: issue of a long-latency destination; in 1/1/5.
- `ra1`, `re1`, `ra2`, `re2`: decode read addresses and enables; in 5/1/5/1.
- `stall_o` out 1: decode must hold; combinational.
- `alu_hold` out 1: ALU writeback must not present a write next cycle (guard builds only).
- `we`, `wa`, `wd` out 1/5/32: registered regfile write port.

## Operation
- **Grant priority:**
  - An ALU write (`alu_we`=1 and `alu_wa`≠0) always wins.
  - Otherwise, pending LSU/MDU requests are served round-robin. A 1-bit pointer `rr` prefers the requester *not* granted last; reset value of `rr` prefers the LSU.
- **Acknowledge:** `*_ack` is asserted combinationally in the grant cycle. The requester drops or replaces `req` on the following edge.
- **Output register:** on each edge the granted source's `wa`/`wd` load into `wa`/`wd`, and `we` loads 1. If nothing is granted, `we` loads 0 and `wa`/`wd` hold their values.
- **r0 handling:** a granted write with address 0 is acked normally, but `we` loads 0.
- **Scoreboard:** 32-bit busy mask; bit 0 is constant 0.
  - Set: `iss_valid`·`iss_long`·(`iss_wa`≠0) sets `busy[iss_wa]`.
  - Clear: an LSU/MDU grant clears `busy[granted wa]` on the same edge the output register loads.
  - Same register set and cleared in the same cycle: set wins.
  - ALU writes never touch the mask.
- **Stall:** `stall_o` = (`re1`·`busy[ra1]`) + (`re2`·`busy[ra2]`).
  - In the cycle after the clear, the regfile's same-cycle write forwarding supplies the data.
  - The scoreboard does not stall decode between the ack edge and `we` in the output register.

## Timing
- **Reset values** (asynchronous, `cpu_rst_n`=0): `we`=0, `wa`=0, `wd`=0, busy=0, `rr`→LSU, starve counter=0, `alu_hold`=0.
- **Acks under reset:** `lsu_ack`=`mdu_ack`=0 while reset is asserted.
- **Reset mid-request:** a request pending at reset is not acked. The requester re-presents it after reset.
- **Grant-to-write latency:** 1 cycle. A grant at edge N produces `we`=1 during cycle N+1.
- **Throughput:** one write per cycle maximum. LSU and MDU requesting together every cycle, with the ALU idle, alternate L,M,L,M.
- **Stall latency:** `stall_o` reflects the mask one cycle after the issue edge that set it, and deasserts in the cycle `we` carries that register.

## Configuration
Macro: `REGFILE_WPORT_STARVE_GUARD_EN`.

**Defined:**
- A counter increments each cycle an LSU/MDU request is pending but blocked by an ALU write. It resets to 0 on any LSU/MDU grant.
- When the counter reaches `STARVE_MAX`−1, `alu_hold` is registered high for exactly one cycle.
- During that cycle the pipeline guarantees `alu_we`=0, so the pending request is granted.
- The counter then returns to 0.

**Undefined:** `alu_hold` is tied 0, no counter exists, and starvation is permitted.

## Structure
- **Shared package** (`defines.v`): `REG_ADDR_BUS`, `REG_BUS`, `REG_NUM`, `WRITE_ENABLE`, `ZERO_WORD`, and new `WB_SRC_ALU/LSU/MDU` encodings for the grant select.
- **Sub-module:** one, `wb_scoreboard`. It holds the busy mask plus set/clear logic and the two-port stall lookup. Arbitration and the output register stay in the top.

## Test plan
- **Reset:** `cpu_rst_n` low mid-stream → `we`=0, `wa`=0, `wd`=0, `stall_o`=0, acks 0. After release, the first LSU request is acked before an MDU request presented the same cycle.
- **ALU pre-empts LSU:** ALU writes r5=0x11111111 while LSU requests r6=0x22222222 → cycle N+1 `we`/r5; `lsu_ack` follows in the next non-ALU cycle; `we`/r6 one cycle later.
- **Round-robin:** LSU (r7) and MDU (r8) request continuously, ALU idle → acks alternate L,M,L,M; output `wa` sequence 7,8,7,8.
- **Scoreboard:**
  - Issue long to r9, then decode `re1`=1, `ra1`=9 → `stall_o`=1 until the MDU grant for r9.
  - `stall_o`=0 in the cycle `we`=1, `wa`=9.
  - Set and clear of r9 in the same cycle → bit stays busy.
- **r0:** MDU request `wa`=0 → `mdu_ack`=1, `we` stays 0; issue long to r0 → `stall_o` never asserts.
- **Starvation guard** (`REGFILE_WPORT_STARVE_GUARD_EN`, `STARVE_MAX`=8): ALU writes every cycle with LSU pending → `alu_hold`=1 after 8 blocked cycles; `lsu_ack` in the held cycle. Without the macro, `alu_hold` stays 0.
